// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, arbiter FSM state encoding and the compute
// function used by both the core ALU and alu_arbiter so encodings never diverge.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;
  localparam logic [3:0] SLT  = 4'd3;
  localparam logic [3:0] SLTU = 4'd4;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] OR   = 4'd8;
  localparam logic [3:0] AND  = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            err;
  } alu_res_t;

  // Codes 10..15 are illegal: result forced to 0 with err set.
  function automatic alu_res_t alu_compute(input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b,
                                           input logic [3:0]      op);
    alu_res_t r;
    r.res = '0;
    r.err = 1'b0;
    case (op)
      ADD:     r.res = a + b;
      SUB:     r.res = a - b;
      SLL:     r.res = a << b[4:0];
      SLT:     r.res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    r.res = {{(XLEN-1){1'b0}}, (a < b)};
      XOR:     r.res = a ^ b;
      SRL:     r.res = a >> b[4:0];
      SRA:     r.res = $unsigned($signed(a) >>> b[4:0]);
      OR:      r.res = a | b;
      AND:     r.res = a & b;
      default: r.err = 1'b1;
    endcase
    r.zero = (r.res == '0);
    return r;
  endfunction

endpackage

// File: rtl/alu_arb_rr.sv
// Two-input round-robin grant logic for alu_arbiter: pointer register plus an
// update strobe that hands priority to the requester that was not just served.
module alu_arb_rr
  import alu_pkg::*;
#(
  parameter int RST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

  logic ptr_q;
  logic eff_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= (RST_PRIO != 0);
    else if (update)
      ptr_q <= ~served;
  end

  // The new owner is visible in the update cycle itself, so a back-to-back
  // arbitration on the response handshake already sees the moved pointer.
  assign eff_ptr = update ? ~served : ptr_q;

  always_comb begin
    grant = req;
    if (req[0] && req[1])
      grant = eff_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one 32-bit ALU between two requesters: round-robin grant, one registered
// execute cycle, held response. Define ALU_ARB_B2B_EN to accept on the response handshake.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W        = 32,
  parameter int RST_PRIO = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_res,
  output logic         rsp_zero,
  output logic         rsp_err
);

  state_t       state;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [3:0]   op_code;
  logic         op_id;
  logic [1:0]   grant;
  logic         rsp_hs;
  logic         update;
  logic         arb_en;
  logic         accept;
  alu_res_t     alu_out;

  assign rsp_hs = op_id ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
  assign update = (state == RESP) && rsp_hs;

`ifdef ALU_ARB_B2B_EN
  assign arb_en = !rst && ((state == IDLE) || update);
`else
  assign arb_en = !rst && (state == IDLE);
`endif

  assign accept     = arb_en && (grant != 2'b00);
  assign req0_ready = arb_en && grant[0];
  assign req1_ready = arb_en && grant[1];
  assign alu_out    = alu_compute(op_a, op_b, op_code);

  alu_arb_rr #(
    .RST_PRIO (RST_PRIO)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .update (update),
    .served (op_id),
    .grant  (grant)
  );

  // Operands and grant id are captured on any accept; the state case only
  // decides where the FSM goes next, so IDLE and RESP share one capture path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      op_id      <= 1'b0;
      rsp_res    <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_a    <= grant[1] ? req1_a  : req0_a;
        op_b    <= grant[1] ? req1_b  : req0_b;
        op_code <= grant[1] ? req1_op : req0_op;
        op_id   <= grant[1];
      end
      case (state)
        IDLE: begin
          if (accept)
            state <= EXEC;
        end
        EXEC: begin
          rsp_res    <= alu_out.res;
          rsp_zero   <= alu_out.zero;
          rsp_err    <= alu_out.err;
          rsp0_valid <= ~op_id;
          rsp1_valid <= op_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, hand sequences for the
// multi-cycle corners, and a scoreboard fed on accept and drained on response.
module tb_alu_arbiter;

`ifdef ALU_ARB_B2B_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_res;
  logic        rsp_zero, rsp_err;

  alu_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp_res    (rsp_res),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference: shifts and signed compare built from plain operations.
  function automatic exp_t ref_alu(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
    exp_t e;
    int   sh;
    sh    = int'(b[4:0]);
    e.id  = id;
    e.err = 1'b0;
    e.res = 32'd0;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a + (~b) + 32'd1;
      4'd2: e.res = a << sh;
      4'd3: e.res = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
      4'd4: e.res = {31'd0, (a < b)};
      4'd5: e.res = a ^ b;
      4'd6: e.res = a >> sh;
      4'd7: begin
        e.res = a >> sh;
        if (a[31])
          for (int i = 0; i < sh; i++) e.res[31-i] = 1'b1;
      end
      4'd8: e.res = a | b;
      4'd9: e.res = a & b;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic pop_check(input logic id);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL sb_unexpected: response on requester %0d, expected none", id);
    end else begin
      e = sb.pop_front();
      checkOutput("sb_id", {31'd0, id}, {31'd0, e.id});
      checkOutput("sb_res", rsp_res, e.res);
      checkOutput("sb_flags", {30'd0, rsp_zero, rsp_err}, {30'd0, e.zero, e.err});
    end
  endtask

  // Scoreboard monitor plus the one-ready / one-response invariants.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      checkOutput("dual_ready", {31'd0, req0_ready && req1_ready}, 32'd0);
      checkOutput("dual_rsp", {31'd0, rsp0_valid && rsp1_valid}, 32'd0);
      if (rsp0_valid && rsp0_ready) pop_check(1'b0);
      if (rsp1_valid && rsp1_ready) pop_check(1'b1);
      if (req0_valid && req0_ready) sb.push_back(ref_alu(1'b0, req0_a, req0_b, req0_op));
      if (req1_valid && req1_ready) sb.push_back(ref_alu(1'b1, req1_a, req1_b, req1_op));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic id, input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [3:0] op);
    if (id) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  function automatic logic ready_of(input logic id);
    return id ? req1_ready : req0_ready;
  endfunction

  function automatic logic rsp_valid_of(input logic id);
    return id ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic wait_ready(input logic id, output int k);
    k = 0;
    while (!ready_of(id) && k < 10) begin
      step(); #1;
      k++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic run_op(input string name, input vec_t v);
    int k;
    applyStimulus(v.id, 1'b1, v.a, v.b, v.op);
    #1;
    wait_ready(v.id, k);
    checkOutput({name, "_accept_wait"}, k, 32'd0);
    step();
    applyStimulus(v.id, 1'b0, v.a, v.b, v.op);
    #1;
    checkOutput({name, "_rsp_early"}, {31'd0, rsp_valid_of(v.id)}, 32'd0);
    step(); #1;
    checkOutput({name, "_rsp_valid"}, {31'd0, rsp_valid_of(v.id)}, 32'd1);
    checkOutput({name, "_res"}, rsp_res, v.res);
    checkOutput({name, "_flags"}, {30'd0, rsp_zero, rsp_err}, {30'd0, v.zero, v.err});
    step(); #1;
    checkOutput({name, "_rsp_drop"}, {31'd0, rsp_valid_of(v.id)}, 32'd0);
  endtask

  initial begin
    vec_t vecs[14];
    int   k;
    int   cyc;
    int   prev_cyc;
    logic prev_id;
    logic have_prev;
    logic gid;

    vecs[0]  = '{1'b0, 32'd5,        32'd7,        4'd0,  32'd12,       1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'd3,        32'd3,        4'd1,  32'd0,        1'b1, 1'b0};
    vecs[2]  = '{1'b1, 32'h80000000, 32'd4,        4'd7,  32'hF8000000, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        4'd3,  32'd1,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'hFFFFFFFF, 32'd1,        4'd4,  32'd0,        1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'd1,        32'd33,       4'd2,  32'd2,        1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h80000000, 32'd31,       4'd6,  32'd1,        1'b0, 1'b0};
    vecs[7]  = '{1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd5,  32'h0FF00FF0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h000000F0, 32'h00000F00, 4'd8,  32'h00000FF0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd9,  32'h0000F000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'd0,        32'd1,        4'd1,  32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'd1,        4'd0,  32'd0,        1'b1, 1'b0};
    vecs[12] = '{1'b0, 32'h0000ABCD, 32'h00001234, 4'd12, 32'd0,        1'b1, 1'b1};
    vecs[13] = '{1'b1, 32'd1,        32'd1,        4'd15, 32'd0,        1'b1, 1'b1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    step();
    step();
    checkOutput("reset_outputs",
                {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err}, 32'd0);
    checkOutput("reset_res", rsp_res, 32'd0);
    rst = 1'b0;
    #1;

    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i]);

    // Both requesters at once after reset: pointer favours requester 0.
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'd3, 32'd3, 4'd1);
    applyStimulus(1'b1, 1'b1, 32'd1, 32'd2, 4'd4);
    #1;
    checkOutput("sim_ready0", {31'd0, req0_ready}, 32'd1);
    checkOutput("sim_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    #1;
    step(); #1;
    checkOutput("sim_rsp0", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("sim_res0", rsp_res, 32'd0);
    checkOutput("sim_zero0", {31'd0, rsp_zero}, 32'd1);
    checkOutput("sim_b2b_ready1", {31'd0, req1_ready}, {31'd0, (GAP == 2)});
    wait_ready(1'b1, k);
    checkOutput("sim_grant1_timeout", {31'd0, (k < 10)}, 32'd1);
    step();
    req1_valid = 1'b0;
    #1;
    step(); #1;
    checkOutput("sim_rsp1", {31'd0, rsp1_valid}, 32'd1);
    checkOutput("sim_res1", rsp_res, 32'd1);
    step(); #1;

    // Back-pressure on requester 1: response held, no new grants.
    rsp1_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h10, 32'h20, 4'd0);
    #1;
    wait_ready(1'b1, k);
    checkOutput("bp_accept_wait", k, 32'd0);
    step();
    req1_valid = 1'b0;
    #1;
    step();
    applyStimulus(1'b0, 1'b1, 32'd1, 32'd1, 4'd0);
    applyStimulus(1'b1, 1'b1, 32'd9, 32'd4, 4'd1);
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_rsp1_held", {31'd0, rsp1_valid}, 32'd1);
      checkOutput("bp_res_held", rsp_res, 32'h30);
      checkOutput("bp_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      step(); #1;
    end
    rsp1_ready = 1'b1;
    #1;
    checkOutput("bp_hs_ready0", {31'd0, req0_ready}, {31'd0, (GAP == 2)});
    checkOutput("bp_hs_ready1", {31'd0, req1_ready}, 32'd0);
    step(); #1;
    checkOutput("bp_after_ready0", {31'd0, req0_ready}, {31'd0, (GAP == 3)});
    checkOutput("bp_after_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    k = 0;
    while (!rsp0_valid && k < 6) begin
      step(); #1;
      k++;
    end
    checkOutput("bp_rsp0_seen", {31'd0, rsp0_valid}, 32'd1);
    checkOutput("bp_res0", rsp_res, 32'd2);
    step(); #1;
    step(); #1;

    // Reset while the op is in EXEC: response must never appear.
    applyStimulus(1'b0, 1'b1, 32'h11, 32'h22, 4'd0);
    #1;
    wait_ready(1'b0, k);
    checkOutput("rst_accept_wait", k, 32'd0);
    step();
    req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    step(); #1;
    checkOutput("rst_exec_outputs",
                {26'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_zero, rsp_err}, 32'd0);
    checkOutput("rst_exec_res", rsp_res, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      checkOutput("rst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    end

    // Continuous contention: grants alternate at the base (or back-to-back) rate.
    do_reset();
    applyStimulus(1'b0, 1'b1, 32'h1234, 32'h00FF, 4'd5);
    applyStimulus(1'b1, 1'b1, 32'h0F00, 32'h00F0, 4'd8);
    #1;
    have_prev = 1'b0;
    prev_id   = 1'b0;
    prev_cyc  = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      if (req0_ready || req1_ready) begin
        gid = req1_ready;
        if (have_prev) begin
          checkOutput("alt_id", {31'd0, gid}, {31'd0, ~prev_id});
          checkOutput("alt_gap", cyc - prev_cyc, GAP);
        end else begin
          checkOutput("alt_first", {31'd0, gid}, 32'd0);
        end
        have_prev = 1'b1;
        prev_id   = gid;
        prev_cyc  = cyc;
      end
      step(); #1;
    end
    checkOutput("alt_seen", {31'd0, have_prev}, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) step();

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
